// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one cache line read/write on the pmem_* side into a
// num_beats-long burst on the main-memory bus, and reports completion back.
//
// Handshake semantics (both sides):
//   Cache side: read_i/write_i are sampled only in IDLE. Once a request is
//   taken, the cache-side inputs are ignored until resp_o has pulsed for one
//   cycle and the FSM is back in IDLE.
//   Memory side: read_o/write_o stay high for the whole burst. Every cycle
//   with resp_i=1 transfers exactly one beat: burst_i is captured on a read,
//   and burst_o is consumed on a write. Cycles with resp_i=0 are gaps that
//   hold all state. resp_i is ignored outside READ/WRITE.
module cacheline_adaptor #(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         address_i,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    output logic [31:0]         address_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i,
    output logic [1:0]          state_o
);

    localparam int cnt_w = $clog2(num_beats);
    localparam int off_w = $clog2(s_line / 8);
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_beats - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [cnt_w-1:0]    cnt;
    logic [cnt_w-1:0]    cnt_nxt;
    logic [s_line-1:0]   wbuf;

    // Byte-offset bits of the incoming address are dropped by line alignment.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[off_w-1:0];

    assign cnt_nxt = cnt + cnt_w'(1);
    assign state_o = state;

    // Burst sequencer: request capture, beat counting and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wbuf      <= '0;
            line_o    <= '0;
            address_o <= '0;
            burst_o   <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (read_i) begin
                        address_o <= {address_i[31:off_w], {off_w{1'b0}}};
                        read_o    <= 1'b1;
                        state     <= READ;
                    end else if (write_i) begin
                        address_o <= {address_i[31:off_w], {off_w{1'b0}}};
                        wbuf      <= line_i;
                        burst_o   <= line_i[s_burst-1:0];
                        write_o   <= 1'b1;
                        state     <= WRITE;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[cnt*s_burst +: s_burst] <= burst_i;
                        cnt <= cnt_nxt;
                        if (cnt == last_cnt) begin
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt <= cnt_nxt;
                        if (cnt == last_cnt) begin
                            write_o <= 1'b0;
                            burst_o <= '0;
                            resp_o  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            // Present the next beat so it is stable before its resp_i.
                            burst_o <= wbuf[cnt_nxt*s_burst +: s_burst];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: read, gapped write, read/write
// priority, back-to-back transactions, stray beats and reset mid-burst.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  address_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [31:0]  address_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;
    logic [1:0]   state_o;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .address_o (address_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i),
        .state_o   (state_o)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] exp_line;

    initial begin
        rst       = 1'b0;
        address_i = '0;
        line_i    = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        chk("rst_resp_o",    256'(resp_o),    256'(0));
        chk("rst_read_o",    256'(read_o),    256'(0));
        chk("rst_write_o",   256'(write_o),   256'(0));
        chk("rst_address_o", 256'(address_o), 256'(0));
        chk("rst_burst_o",   256'(burst_o),   256'(0));
        chk("rst_line_o",    line_o,          256'(0));
        chk("rst_state",     256'(state_o),   256'(S_IDLE));
        rst = 1'b1;
        tick();
        chk("idle_read_o", 256'(read_o), 256'(0));

        // ---------------- read, contiguous beats 2..5, resp_o in cycle 6
        address_i = 32'h1234_5678;
        read_i    = 1'b1;
        tick();                                   // edge 0 -> cycle 1
        read_i    = 1'b0;
        address_i = 32'hFFFF_FFFF;                // ignored after acceptance
        chk("rd_read_o_c1",  256'(read_o),    256'(1));
        chk("rd_addr_c1",    256'(address_o), 256'(32'h1234_5660));
        chk("rd_state_c1",   256'(state_o),   256'(S_READ));
        tick();                                   // cycle 2
        for (int b = 1; b <= 4; b++) begin
            resp_i  = 1'b1;
            burst_i = 64'(b);
            chk("rd_no_resp_early", 256'(resp_o), 256'(0));
            tick();
        end
        resp_i  = 1'b0;
        burst_i = '0;
        chk("rd_resp_c6",   256'(resp_o),    256'(1));
        chk("rd_read_o_c6", 256'(read_o),    256'(0));
        chk("rd_line_o",    line_o,          {64'h4, 64'h3, 64'h2, 64'h1});
        chk("rd_addr_c6",   256'(address_o), 256'(32'h1234_5660));
        tick();
        chk("rd_resp_c7",   256'(resp_o),    256'(0));
        chk("rd_state_c7",  256'(state_o),   256'(S_IDLE));
        chk("rd_line_hold", line_o,          {64'h4, 64'h3, 64'h2, 64'h1});

        // ---------------- write with gap: resp_i on cycles 2,3,6,7
        line_a    = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        line_i    = line_a;
        address_i = 32'hABCD_EF9F;
        write_i   = 1'b1;
        tick();                                   // cycle 1
        write_i   = 1'b0;
        line_i    = '0;                           // ignored after acceptance
        chk("wr_write_o_c1", 256'(write_o),   256'(1));
        chk("wr_read_o_c1",  256'(read_o),    256'(0));
        chk("wr_addr_c1",    256'(address_o), 256'(32'hABCD_EF80));
        chk("wr_burst_c1",   256'(burst_o),   256'(64'hAAAA_AAAA_AAAA_AAAA));
        tick();                                   // cycle 2
        resp_i = 1'b1;
        chk("wr_burst_c2", 256'(burst_o), 256'(64'hAAAA_AAAA_AAAA_AAAA));
        tick();                                   // cycle 3
        chk("wr_burst_c3", 256'(burst_o), 256'(64'hBBBB_BBBB_BBBB_BBBB));
        tick();                                   // cycle 4
        resp_i = 1'b0;
        chk("wr_burst_c4", 256'(burst_o), 256'(64'hCCCC_CCCC_CCCC_CCCC));
        tick();                                   // cycle 5
        chk("wr_burst_c5", 256'(burst_o), 256'(64'hCCCC_CCCC_CCCC_CCCC));
        chk("wr_resp_gap", 256'(resp_o),  256'(0));
        tick();                                   // cycle 6
        resp_i = 1'b1;
        chk("wr_burst_c6", 256'(burst_o), 256'(64'hCCCC_CCCC_CCCC_CCCC));
        tick();                                   // cycle 7
        chk("wr_burst_c7", 256'(burst_o), 256'(64'hDDDD_DDDD_DDDD_DDDD));
        chk("wr_resp_c7",  256'(resp_o),  256'(0));
        tick();                                   // cycle 8
        resp_i = 1'b0;
        chk("wr_resp_c8",    256'(resp_o),  256'(1));
        chk("wr_write_o_c8", 256'(write_o), 256'(0));
        chk("wr_burst_c8",   256'(burst_o), 256'(0));
        chk("wr_line_kept",  line_o,        {64'h4, 64'h3, 64'h2, 64'h1});
        tick();
        chk("wr_resp_c9", 256'(resp_o), 256'(0));

        // ---------------- read and write together: read wins
        address_i = 32'h0000_1040;
        line_i    = {4{64'h5555_5555_5555_5555}};
        read_i    = 1'b1;
        write_i   = 1'b1;
        tick();
        read_i    = 1'b0;
        write_i   = 1'b0;
        chk("both_read_o",  256'(read_o),    256'(1));
        chk("both_write_o", 256'(write_o),   256'(0));
        chk("both_addr",    256'(address_o), 256'(32'h0000_1040));
        chk("both_burst_o", 256'(burst_o),   256'(0));
        for (int b = 5; b <= 8; b++) begin
            resp_i  = 1'b1;
            burst_i = 64'(b);
            tick();
        end
        resp_i = 1'b0;
        chk("both_resp",   256'(resp_o), 256'(1));
        chk("both_line_o", line_o,       {64'h8, 64'h7, 64'h6, 64'h5});
        tick();

        // ---------------- write then read back to back
        line_b    = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                     64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        line_i    = line_b;
        address_i = 32'h0000_2020;
        write_i   = 1'b1;
        tick();                                   // cycle 1, WRITE
        write_i   = 1'b0;
        chk("b2b_wr_addr", 256'(address_o), 256'(32'h0000_2020));
        resp_i = 1'b1;                            // beats on cycles 1..4
        chk("b2b_burst_b0", 256'(burst_o), 256'(64'h0101_0101_0101_0101));
        tick();
        chk("b2b_burst_b1", 256'(burst_o), 256'(64'h0202_0202_0202_0202));
        tick();
        chk("b2b_burst_b2", 256'(burst_o), 256'(64'h0303_0303_0303_0303));
        tick();
        chk("b2b_burst_b3", 256'(burst_o), 256'(64'h0404_0404_0404_0404));
        tick();                                   // cycle 5, DONE
        resp_i = 1'b0;
        chk("b2b_wr_resp", 256'(resp_o), 256'(1));
        address_i = 32'h0000_3000;
        read_i    = 1'b1;                         // held through DONE
        tick();                                   // cycle 6, IDLE
        chk("b2b_done_not_taken", 256'(read_o),  256'(0));
        chk("b2b_idle_state",     256'(state_o), 256'(S_IDLE));
        chk("b2b_no_resp_idle",   256'(resp_o),  256'(0));
        tick();                                   // cycle 7, READ
        read_i = 1'b0;
        chk("b2b_rd_taken", 256'(read_o),    256'(1));
        chk("b2b_rd_addr",  256'(address_o), 256'(32'h0000_3000));
        for (int b = 1; b <= 4; b++) begin
            resp_i  = 1'b1;
            burst_i = 64'(b * 16 + b);            // 0x11, 0x22, 0x33, 0x44
            tick();
        end
        // DONE cycle: leave a stray beat on the bus
        burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_line = {64'h44, 64'h33, 64'h22, 64'h11};
        chk("b2b_rd_resp", 256'(resp_o), 256'(1));
        chk("b2b_rd_line", line_o,       exp_line);

        // ---------------- stray beats in DONE and IDLE
        tick();                                   // IDLE, resp_i still high
        chk("stray_done_line", line_o,          exp_line);
        chk("stray_done_resp", 256'(resp_o),    256'(0));
        tick();
        chk("stray_idle_line",  line_o,         exp_line);
        chk("stray_idle_resp",  256'(resp_o),   256'(0));
        chk("stray_idle_state", 256'(state_o),  256'(S_IDLE));
        chk("stray_idle_rd",    256'(read_o),   256'(0));
        resp_i  = 1'b0;
        burst_i = '0;
        tick();

        // ---------------- asynchronous reset after beat 2 of a read
        address_i = 32'h0000_5000;
        read_i    = 1'b1;
        tick();
        read_i    = 1'b0;
        resp_i    = 1'b1;
        burst_i   = 64'h77;
        tick();
        burst_i   = 64'h88;
        tick();                                   // two beats taken, cnt=2
        resp_i    = 1'b0;
        chk("rstmid_pre_read_o", 256'(read_o), 256'(1));
        #2;
        rst = 1'b0;                               // between clock edges
        #1;
        chk("rstmid_read_o",  256'(read_o),    256'(0));
        chk("rstmid_resp_o",  256'(resp_o),    256'(0));
        chk("rstmid_addr_o",  256'(address_o), 256'(0));
        chk("rstmid_line_o",  line_o,          256'(0));
        chk("rstmid_state",   256'(state_o),   256'(S_IDLE));
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_no_resp", 256'(resp_o), 256'(0));

        // new read after reset must start from beat 0
        address_i = 32'h0000_6010;
        read_i    = 1'b1;
        tick();
        read_i    = 1'b0;
        chk("post_rst_read_o", 256'(read_o),    256'(1));
        chk("post_rst_addr",   256'(address_o), 256'(32'h0000_6000));
        for (int b = 1; b <= 4; b++) begin
            resp_i  = 1'b1;
            burst_i = 64'(32'hA0 + b);
            tick();
        end
        resp_i = 1'b0;
        chk("post_rst_resp", 256'(resp_o), 256'(1));
        chk("post_rst_line", line_o,       {64'hA4, 64'hA3, 64'hA2, 64'hA1});
        tick();
        chk("post_rst_idle", 256'(resp_o), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
